// File: rtl/leg_solver_if.sv
// Start/busy/done handshake bundle for the leg solver: operands in, leg/remainder/status out.
interface leg_solver_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] r_in;
  logic [W-1:0] x_in;
  logic         busy;
  logic         done;
  logic [W-1:0] y_out;
  logic [W:0]   rem_out;
  logic         exact;
  logic         err;

  modport master (output start, r_in, x_in,
                  input  busy, done, y_out, rem_out, exact, err);
  modport slave  (input  start, r_in, x_in,
                  output busy, done, y_out, rem_out, exact, err);
endinterface

// File: rtl/leg_solver.sv
// Computes y = floor(sqrt(r*r - x*x)) with a digit-by-digit integer square root,
// one result bit per clock, behind a start/busy/done handshake.
module leg_solver #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  leg_solver_if.slave  bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t         state;
  logic [W-1:0]   r_q, x_q;
  logic [2*W-1:0] d;
  logic [W-1:0]   root;
  logic [W:0]     rem;
  logic [CW-1:0]  cnt;

  logic           busy_q, done_q, exact_q, err_q;
  logic [W-1:0]   y_q;
  logic [W:0]     rem_out_q;

  logic [2*W-1:0]      r_ext, x_ext, d_calc;
  logic [1:0]          pair;
  logic signed [W+3:0] trial;
  logic [W-1:0]        root_nxt;
  logic [W:0]          rem_nxt;

  assign r_ext  = {{W{1'b0}}, r_q};
  assign x_ext  = {{W{1'b0}}, x_q};
  // Only consumed when r >= x, so the difference never wraps.
  assign d_calc = r_ext * r_ext - x_ext * x_ext;
  assign pair   = d[2*W-1 -: 2];

  // One square-root step: a non-negative trial keeps the subtraction and sets the root bit.
  always_comb begin
    trial    = $signed({1'b0, rem, pair}) - $signed({2'b00, root, 2'b01});
    root_nxt = {root[W-2:0], 1'b0};
    rem_nxt  = (W+1)'({rem, pair});
    if (!trial[W+3]) begin
      root_nxt = {root[W-2:0], 1'b1};
      rem_nxt  = (W+1)'(trial);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_q       <= '0;
      x_q       <= '0;
      d         <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exact_q   <= 1'b0;
      err_q     <= 1'b0;
      y_q       <= '0;
      rem_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          r_q    <= bus.r_in;
          x_q    <= bus.x_in;
          err_q  <= 1'b0;
          busy_q <= 1'b1;
          state  <= LOAD;
        end
        LOAD: if (r_q < x_q) begin
          err_q     <= 1'b1;
          y_q       <= '0;
          rem_out_q <= '0;
          exact_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state     <= DONE;
        end else begin
          d     <= d_calc;
          root  <= '0;
          rem   <= '0;
          cnt   <= CW'(W - 1);
          state <= ITER;
        end
        ITER: begin
          d    <= d << 2;
          root <= root_nxt;
          rem  <= rem_nxt;
          if (cnt == '0) begin
            y_q       <= root_nxt;
            rem_out_q <= rem_nxt;
            exact_q   <= (rem_nxt == '0);
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.y_out   = y_q;
  assign bus.rem_out = rem_out_q;
  assign bus.exact   = exact_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_leg_solver.sv
// Directed and randomized checks of leg_solver against an arithmetic model of y = floor(sqrt(r^2 - x^2)).
module tb_leg_solver;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   hold_y = 0, hold_rem = 0, hold_exact = 0, hold_err = 0;

  leg_solver_if #(.W(W)) bus ();
  leg_solver #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the triangle, no iteration structure.
  task automatic model(input int r, input int x, output int y, output int rem,
                       output bit e, output int d);
    e = (x > r);
    d = e ? 0 : r * r - x * x;
    y = 0;
    while ((y + 1) * (y + 1) <= d) y++;
    rem = d - y * y;
  endtask

  task automatic do_op(input int r, input int x, input bit poke);
    int y, rem, d, lat;
    bit e;
    model(r, x, y, rem, e, d);
    lat = e ? 2 : W + 2;
    @(negedge clk);
    check("idle_done_low", bus.done, 0);
    check("hold_y", bus.y_out, hold_y);
    check("hold_rem", bus.rem_out, hold_rem);
    check("hold_exact", bus.exact, hold_exact);
    bus.start = 1'b1;
    bus.r_in  = W'(r);
    bus.x_in  = W'(x);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.r_in  = W'($urandom);
      bus.x_in  = W'($urandom);
      if (poke && (n == 4)) bus.start = 1'b1;
      if (n < lat) begin
        check($sformatf("busy_n%0d r%0d x%0d", n, r, x), bus.busy, 1);
        check($sformatf("done_early_n%0d r%0d x%0d", n, r, x), bus.done, 0);
      end
    end
    bus.start = 1'b0;
    check($sformatf("done r%0d x%0d", r, x), bus.done, 1);
    check($sformatf("busy_at_done r%0d x%0d", r, x), bus.busy, 0);
    check($sformatf("y r%0d x%0d", r, x), bus.y_out, y);
    check($sformatf("rem r%0d x%0d", r, x), bus.rem_out, rem);
    check($sformatf("exact r%0d x%0d", r, x), bus.exact, (!e && rem == 0));
    check($sformatf("err r%0d x%0d", r, x), bus.err, e);
    if (!e) begin
      check($sformatf("inv_sum r%0d x%0d", r, x),
            longint'(bus.y_out) * bus.y_out + bus.rem_out, d);
      check($sformatf("inv_rem r%0d x%0d", r, x), (bus.rem_out <= 2 * bus.y_out), 1);
    end
    hold_y = y; hold_rem = rem; hold_exact = (!e && rem == 0); hold_err = e;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.r_in  = '0;
    bus.x_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_y", bus.y_out, 0);
    check("rst_rem", bus.rem_out, 0);
    check("rst_exact", bus.exact, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;

    do_op(25, 7, 0);
    do_op(10, 8, 0);

    // Abort mid-iteration with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1; bus.r_in = 8'd25; bus.x_in = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_y", bus.y_out, 0);
    check("abort_rem", bus.rem_out, 0);
    check("abort_exact", bus.exact, 0);
    check("abort_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_y = 0; hold_rem = 0; hold_exact = 0; hold_err = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
    end

    do_op(5, 3, 0);
    do_op(18, 10, 0);
    do_op(3, 5, 0);
    do_op(255, 0, 0);
    do_op(0, 0, 0);
    do_op(255, 254, 0);
    do_op(25, 7, 1);

    for (int i = 0; i < 30; i++) begin
      int r, x;
      r = int'($urandom_range(0, 255));
      x = (($urandom % 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, r));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(r, x, bit'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
